pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have the following parameters, each given as name, default, meaning:
- RF_ADDRESS, 5, register-index width.
- FWD_EN, 1, 1 = full forwarding with load-use stall only; 0 = no forwarding, stall on any in-flight writer.
- MEM_WAIT_EN, 1, 1 = honour mem_ready; 0 = mem_ready ignored, memory always ready.
- CNT_W, 16, stall-counter width.
REQ-002 The block SHALL have the following ports, each given as name  direction  width  meaning:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- id_valid  in  1  IF/ID holds a real instruction.
- id_rs1, id_rs2  in  RF_ADDRESS  ID source registers.
- id_rs1_used, id_rs2_used  in  1  the source is read.
- id_rd  in  RF_ADDRESS  ID destination register.
- id_regwrite, id_memread, id_memaccess  in  1  ID controls; memaccess = MemRead|MemWrite.
- ex_redirect  in  1  branch/jump taken in EX.
- mem_ready  in  1  data memory completes the MEM-stage access this cycle.
- pc_stall, ifid_stall, ifid_flush, idex_bubble, pipe_freeze  out  1  pipeline-register controls.
- fwd_a_sel, fwd_b_sel  out  2  EX operand source: 00 = register file, 01 = WB, 10 = MEM.
- ex_valid, mem_valid, wb_valid, wb_regwrite  out  1  stage occupancy and WB write enable.
- mem_req  out  1  MEM-stage access request.
- stall_count  out  CNT_W  pc_stall cycle count.
REQ-003 Reset SHALL be synchronous and active-high on reset, and the block SHALL use the single clock clk.

Function
REQ-004 The block SHALL keep one shadow entry per stage for EX, MEM and WB, each holding {valid, rs1, rs2, rd, regwrite, memread, memaccess}.
REQ-005 A stage entry SHALL be a "writer" when valid=1, regwrite=1 and rd!=0; register x0 SHALL never match.
REQ-006 With FWD_EN=1, load_use SHALL be 1 when id_valid=1, the EX entry is a writer with memread=1, and EX.rd equals a used ID source.
REQ-007 With FWD_EN=0, load_use SHALL be 1 when id_valid=1 and a used ID source equals the rd of any writer in EX, MEM or WB; the register file has no write-through.
REQ-008 Memory freeze SHALL be asserted when MEM_WAIT_EN=1, mem_valid=1, MEM.memaccess=1 and mem_ready=0.
REQ-009 The freeze FSM SHALL have states IDLE and WAIT:
- IDLE to WAIT when freeze is asserted.
- WAIT to IDLE in the cycle mem_ready=1.
- pipe_freeze SHALL equal the combinational freeze condition in both states.
REQ-010 mem_req SHALL equal mem_valid & MEM.memaccess and SHALL stay high throughout WAIT.
REQ-011 Control priority SHALL be freeze > redirect > load_use.
REQ-012 Under freeze:
- pc_stall and ifid_stall SHALL be 1, and ifid_flush and idex_bubble SHALL be 0.
- The EX and MEM entries SHALL hold.
- WB SHALL load an invalid entry.
- ex_redirect SHALL be ignored until the freeze ends.
REQ-013 Under redirect (ex_valid & ex_redirect, no freeze):
- ifid_flush and idex_bubble SHALL be 1, and pc_stall SHALL be 0.
- EX SHALL load invalid, MEM SHALL load EX, and WB SHALL load MEM.
REQ-014 Under load_use (no freeze, no redirect):
- pc_stall, ifid_stall and idex_bubble SHALL be 1.
- EX SHALL load invalid, MEM SHALL load EX, and WB SHALL load MEM.
REQ-015 Otherwise all controls SHALL be 0 and EX SHALL load the ID fields, with valid = id_valid.
REQ-016 For each operand, the forward select SHALL be:
- 10 if the MEM entry is a writer and its rd equals the EX source;
- else 01 if the WB entry is a writer with a matching rd;
- else 00.
MEM SHALL take priority over WB. With FWD_EN=0, both selects SHALL be 00.
REQ-017 fwd_a_sel/fwd_b_sel SHALL be 00 when ex_valid=0.
REQ-018 All control and forward outputs SHALL be combinational from the current entries and inputs, with zero added latency.
REQ-019 wb_regwrite SHALL equal WB.valid & WB.regwrite.
REQ-020 stall_count SHALL increment by 1 each cycle pc_stall=1 and SHALL saturate at 2^CNT_W-1 without wrapping.

Reset
REQ-021 While reset=1 at a clk edge:
- all entry valid bits SHALL clear;
- the FSM SHALL go to IDLE;
- stall_count SHALL go to 0.
REQ-022 After reset:
- every 1-bit output SHALL be 0, including while id_valid=1;
- fwd_a_sel and fwd_b_sel SHALL be 00;
- stall_count SHALL be 0.
REQ-023 Reset asserted during WAIT or during a stall SHALL abandon the operation within that cycle, with no stale entry surviving.

Verification
REQ-024 Load-use: lw x5 in EX, then ID add using x5 (rs1_used=1) -> exactly one cycle with pc_stall=ifid_stall=idex_bubble=1; on the next cycle fwd_a_sel=01; stall_count=1.
REQ-025 Back-to-back ALU dependency: add x3 then sub x4,x3,x3 -> no stall; fwd_a_sel=fwd_b_sel=10 with sub in EX; writes to x0 produce 00.
REQ-026 Memory wait: sw in MEM with mem_ready low for 3 cycles -> pipe_freeze=1 and mem_req=1 for 3 cycles; wb_valid=0 during the wait; EX contents unchanged; the following instruction completes afterwards.
REQ-027 Simultaneous events:
- ex_redirect=1 while MEM waits -> no flush until mem_ready=1;
- then one cycle with ifid_flush=idex_bubble=1;
- redirect plus load_use in the same cycle -> flush only, pc_stall=0.
REQ-028 FWD_EN=0: a writer to x7 in WB and an ID read of x7 -> pc_stall=1 for one cycle; a writer in EX -> 3 stall cycles; fwd_*_sel remain 00.
REQ-029 Saturation and reset: CNT_W=4 with a continuous stall -> stall_count stops at 15; reset asserted in WAIT -> next cycle all outputs 0 and FSM IDLE.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a 5-stage in-order pipeline: shadows EX/MEM/WB, drives stall,
// flush, bubble and freeze controls, operand forwarding selects and a stall counter.
module pipe_hazard_ctrl #(
  parameter int RF_ADDRESS  = 5,
  parameter int FWD_EN      = 1,
  parameter int MEM_WAIT_EN = 1,
  parameter int CNT_W       = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    id_valid,
  input  logic [RF_ADDRESS-1:0]   id_rs1,
  input  logic [RF_ADDRESS-1:0]   id_rs2,
  input  logic                    id_rs1_used,
  input  logic                    id_rs2_used,
  input  logic [RF_ADDRESS-1:0]   id_rd,
  input  logic                    id_regwrite,
  input  logic                    id_memread,
  input  logic                    id_memaccess,
  input  logic                    ex_redirect,
  input  logic                    mem_ready,
  output logic                    pc_stall,
  output logic                    ifid_stall,
  output logic                    ifid_flush,
  output logic                    idex_bubble,
  output logic                    pipe_freeze,
  output logic [1:0]              fwd_a_sel,
  output logic [1:0]              fwd_b_sel,
  output logic                    ex_valid,
  output logic                    mem_valid,
  output logic                    wb_valid,
  output logic                    wb_regwrite,
  output logic                    mem_req,
  output logic [CNT_W-1:0]        stall_count,
  output logic                    dbg_state,
  output logic [3*RF_ADDRESS+3:0] dbg_wb
);

  typedef struct packed {
    logic                  valid;
    logic [RF_ADDRESS-1:0] rs1;
    logic [RF_ADDRESS-1:0] rs2;
    logic [RF_ADDRESS-1:0] rd;
    logic                  regwrite;
    logic                  memread;
    logic                  memaccess;
  } entry_t;

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  entry_t ex_q, mem_q, wb_q, ex_d, mem_d, wb_d, id_entry;
  state_t state_q, state_d;
  logic   freeze, redirect, load_use;

  function automatic logic is_writer(input entry_t e);
    return e.valid && e.regwrite && (e.rd != '0);
  endfunction

  function automatic logic src_hit(input entry_t e, input logic [RF_ADDRESS-1:0] src,
                                   input logic used);
    return used && is_writer(e) && (e.rd == src);
  endfunction

  function automatic logic [1:0] fwd_sel(input entry_t ex, input entry_t mem, input entry_t wb,
                                         input logic [RF_ADDRESS-1:0] src);
    logic [1:0] sel;
    sel = 2'b00;
    if ((FWD_EN != 0) && ex.valid) begin
      if (is_writer(mem) && (mem.rd == src))     sel = 2'b10;
      else if (is_writer(wb) && (wb.rd == src))  sel = 2'b01;
    end
    return sel;
  endfunction

  assign id_entry = '{valid: id_valid, rs1: id_rs1, rs2: id_rs2, rd: id_rd,
                      regwrite: id_regwrite, memread: id_memread, memaccess: id_memaccess};

  // Memory handshake: the MEM access completes in a cycle with mem_req & mem_ready;
  // mem_req & !mem_ready freezes the pipe and mem_req is held until completion.
  always_comb begin
    freeze   = (MEM_WAIT_EN != 0) && mem_q.valid && mem_q.memaccess && !mem_ready;
    redirect = ex_q.valid && ex_redirect && !freeze;
    if (FWD_EN != 0) begin
      load_use = id_valid && ex_q.memread &&
                 (src_hit(ex_q, id_rs1, id_rs1_used) || src_hit(ex_q, id_rs2, id_rs2_used));
    end else begin
      // No register-file write-through, so any in-flight writer blocks the read.
      load_use = id_valid &&
                 (src_hit(ex_q,  id_rs1, id_rs1_used) || src_hit(ex_q,  id_rs2, id_rs2_used) ||
                  src_hit(mem_q, id_rs1, id_rs1_used) || src_hit(mem_q, id_rs2, id_rs2_used) ||
                  src_hit(wb_q,  id_rs1, id_rs1_used) || src_hit(wb_q,  id_rs2, id_rs2_used));
    end
  end

  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    ex_d        = id_entry;
    mem_d       = ex_q;
    wb_d        = mem_q;
    if (freeze) begin
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
      ex_d       = ex_q;
      mem_d      = mem_q;
      wb_d       = '0;
    end else if (redirect) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      ex_d        = '0;
    end else if (load_use) begin
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      idex_bubble = 1'b1;
      ex_d        = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (freeze) state_d = S_WAIT;
      S_WAIT:  if (mem_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      state_q     <= S_IDLE;
      stall_count <= '0;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      state_q <= state_d;
      if (pc_stall && (stall_count != '1)) stall_count <= stall_count + 1'b1;
    end
  end

  assign pipe_freeze = freeze;
  assign mem_req     = mem_q.valid && mem_q.memaccess;
  assign fwd_a_sel   = fwd_sel(ex_q, mem_q, wb_q, ex_q.rs1);
  assign fwd_b_sel   = fwd_sel(ex_q, mem_q, wb_q, ex_q.rs2);
  assign ex_valid    = ex_q.valid;
  assign mem_valid   = mem_q.valid;
  assign wb_valid    = wb_q.valid;
  assign wb_regwrite = wb_q.valid && wb_q.regwrite;
  assign dbg_state   = state_q;
  assign dbg_wb      = wb_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: a forwarding instance (A) and a no-forwarding CNT_W=4 instance (B)
// share one stimulus stream and are compared each cycle against a pipeline-occupancy model.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       regwrite;
    logic       memread;
    logic       memaccess;
  } ent_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_rs1_used, id_rs2_used, id_regwrite, id_memread, id_memaccess;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       ex_redirect, mem_ready;
  logic [1:0] pc_stall, ifid_stall, ifid_flush, idex_bubble, pipe_freeze;
  logic [1:0] ex_valid, mem_valid, wb_valid, wb_regwrite, mem_req, dbg_state;
  logic [1:0] fwd_a [2];
  logic [1:0] fwd_b [2];
  logic [18:0] dbg_wb [2];
  logic [15:0] sc0;
  logic [3:0]  sc1;

  // model: stage 0 = EX, 1 = MEM, 2 = WB
  ent_t ms [2][3];
  ent_t mn [2][3];
  bit   mw [2];
  bit   mwn [2];
  int   mc [2];
  int   mcn [2];
  int   checks = 0;
  int   errors = 0;
  int   c_before;

  always #5 clk = ~clk;

  pipe_hazard_ctrl u_a (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memaccess(id_memaccess),
    .ex_redirect(ex_redirect), .mem_ready(mem_ready),
    .pc_stall(pc_stall[0]), .ifid_stall(ifid_stall[0]), .ifid_flush(ifid_flush[0]),
    .idex_bubble(idex_bubble[0]), .pipe_freeze(pipe_freeze[0]),
    .fwd_a_sel(fwd_a[0]), .fwd_b_sel(fwd_b[0]), .ex_valid(ex_valid[0]),
    .mem_valid(mem_valid[0]), .wb_valid(wb_valid[0]), .wb_regwrite(wb_regwrite[0]),
    .mem_req(mem_req[0]), .stall_count(sc0), .dbg_state(dbg_state[0]), .dbg_wb(dbg_wb[0])
  );

  pipe_hazard_ctrl #(.FWD_EN(0), .CNT_W(4)) u_b (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memaccess(id_memaccess),
    .ex_redirect(ex_redirect), .mem_ready(mem_ready),
    .pc_stall(pc_stall[1]), .ifid_stall(ifid_stall[1]), .ifid_flush(ifid_flush[1]),
    .idex_bubble(idex_bubble[1]), .pipe_freeze(pipe_freeze[1]),
    .fwd_a_sel(fwd_a[1]), .fwd_b_sel(fwd_b[1]), .ex_valid(ex_valid[1]),
    .mem_valid(mem_valid[1]), .wb_valid(wb_valid[1]), .wb_regwrite(wb_regwrite[1]),
    .mem_req(mem_req[1]), .stall_count(sc1), .dbg_state(dbg_state[1]), .dbg_wb(dbg_wb[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit writes(input ent_t e);
    return e.valid && e.regwrite && (e.rd != 5'd0);
  endfunction

  // Youngest in-flight producer wins; only instance A forwards.
  function automatic logic [1:0] exp_fwd(input int d, input logic [4:0] src);
    if (d != 0 || !ms[d][0].valid) return 2'b00;
    for (int s = 1; s < 3; s++)
      if (writes(ms[d][s]) && ms[d][s].rd == src) return (s == 1) ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [31:0] sc_of(input int d);
    return (d == 0) ? {16'd0, sc0} : {28'd0, sc1};
  endfunction

  task automatic model_check(input int d);
    string p;
    ent_t  nw;
    bit    frz, rdx, lu, pcs, elig;
    int    cmax;
    p    = (d == 0) ? "A" : "B";
    cmax = (d == 0) ? 65535 : 15;
    frz  = ms[d][1].valid && ms[d][1].memaccess && !mem_ready;
    rdx  = ms[d][0].valid && ex_redirect && !frz;
    lu   = 1'b0;
    for (int s = 0; s < 3; s++) begin
      elig = (d == 0) ? (s == 0 && ms[d][s].memread) : 1'b1;
      if (id_valid && elig && writes(ms[d][s]) &&
          ((id_rs1_used && ms[d][s].rd == id_rs1) || (id_rs2_used && ms[d][s].rd == id_rs2)))
        lu = 1'b1;
    end
    pcs = frz || (!rdx && lu);
    chk({p, ".pc_stall"},    32'(pc_stall[d]),    32'(pcs));
    chk({p, ".ifid_stall"},  32'(ifid_stall[d]),  32'(pcs));
    chk({p, ".ifid_flush"},  32'(ifid_flush[d]),  32'(rdx));
    chk({p, ".idex_bubble"}, 32'(idex_bubble[d]), 32'(!frz && (rdx || lu)));
    chk({p, ".pipe_freeze"}, 32'(pipe_freeze[d]), 32'(frz));
    chk({p, ".fwd_a_sel"},   32'(fwd_a[d]),       32'(exp_fwd(d, ms[d][0].rs1)));
    chk({p, ".fwd_b_sel"},   32'(fwd_b[d]),       32'(exp_fwd(d, ms[d][0].rs2)));
    chk({p, ".ex_valid"},    32'(ex_valid[d]),    32'(ms[d][0].valid));
    chk({p, ".mem_valid"},   32'(mem_valid[d]),   32'(ms[d][1].valid));
    chk({p, ".wb_valid"},    32'(wb_valid[d]),    32'(ms[d][2].valid));
    chk({p, ".wb_regwrite"}, 32'(wb_regwrite[d]), 32'(ms[d][2].valid && ms[d][2].regwrite));
    chk({p, ".mem_req"},     32'(mem_req[d]),     32'(ms[d][1].valid && ms[d][1].memaccess));
    chk({p, ".stall_count"}, sc_of(d),            32'(mc[d]));
    chk({p, ".fsm_state"},   32'(dbg_state[d]),   32'(mw[d]));
    if (reset) begin
      for (int s = 0; s < 3; s++) mn[d][s] = '0;
      mwn[d] = 1'b0;
      mcn[d] = 0;
    end else begin
      mcn[d] = (pcs && mc[d] < cmax) ? mc[d] + 1 : mc[d];
      mwn[d] = mw[d] ? !mem_ready : frz;
      if (frz) begin
        mn[d][0] = ms[d][0];
        mn[d][1] = ms[d][1];
        mn[d][2] = '0;
      end else begin
        nw = {id_valid, id_rs1, id_rs2, id_rd, id_regwrite, id_memread, id_memaccess};
        if (rdx || lu) nw = '0;
        mn[d][2] = ms[d][1];
        mn[d][1] = ms[d][0];
        mn[d][0] = nw;
      end
    end
  endtask

  task automatic settle();
    #4;
    model_check(0);
    model_check(1);
  endtask

  task automatic advance();
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      for (int s = 0; s < 3; s++) ms[d][s] = mn[d][s];
      mw[d] = mwn[d];
      mc[d] = mcn[d];
    end
    #1;
  endtask

  task automatic cycle();
    settle();
    advance();
  endtask

  task automatic set_id(input bit v, input logic [4:0] r1, input logic [4:0] r2, input bit u1,
                        input bit u2, input logic [4:0] rd, input bit rw, input bit mr,
                        input bit ma);
    id_valid = v;  id_rs1 = r1; id_rs2 = r2; id_rs1_used = u1; id_rs2_used = u2;
    id_rd = rd; id_regwrite = rw; id_memread = mr; id_memaccess = ma;
  endtask

  task automatic drain();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    mem_ready   = 1'b1;
    ex_redirect = 1'b0;
    repeat (3) cycle();
  endtask

  task automatic chk_quiet(input int d);
    string p;
    p = (d == 0) ? "A" : "B";
    chk({p, ".quiet_ctrl"}, 32'({pc_stall[d], ifid_stall[d], ifid_flush[d], idex_bubble[d],
                                 pipe_freeze[d], mem_req[d]}), 32'd0);
    chk({p, ".quiet_occ"},  32'({ex_valid[d], mem_valid[d], wb_valid[d], wb_regwrite[d]}), 32'd0);
    chk({p, ".quiet_fwd"},  32'({fwd_a[d], fwd_b[d]}), 32'd0);
    chk({p, ".quiet_cnt"},  sc_of(d), 32'd0);
    chk({p, ".quiet_fsm"},  32'(dbg_state[d]), 32'd0);
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b1; ex_redirect = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      for (int s = 0; s < 3; s++) ms[d][s] = '0;
      mw[d] = 1'b0;
      mc[d] = 0;
    end
    cycle();
    reset = 1'b0;

    // Out of reset with a real instruction in ID: everything quiet.
    set_id(1, 5, 5, 1, 1, 5, 1, 1, 1);
    settle(); chk_quiet(0); chk_quiet(1); advance();

    // lw x5 in EX, add x6,x5,x1 in ID.
    set_id(1, 5, 1, 1, 0, 6, 1, 0, 0);
    settle();
    chk("lu.pc_stall", 32'(pc_stall[0]), 32'd1);
    chk("lu.ifid_stall", 32'(ifid_stall[0]), 32'd1);
    chk("lu.idex_bubble", 32'(idex_bubble[0]), 32'd1);
    advance();
    settle(); chk("lu.one_cycle", 32'(pc_stall[0]), 32'd0); advance();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    chk("lu.fwd_a_wb", 32'(fwd_a[0]), 32'd1);
    chk("lu.stall_count", 32'(sc0), 32'd1);
    advance();
    drain();

    // add x3 then sub x4,x3,x3; then x0 producer.
    set_id(1, 1, 2, 1, 1, 3, 1, 0, 0); cycle();
    set_id(1, 3, 3, 1, 1, 4, 1, 0, 0);
    settle(); chk("alu.no_stall", 32'(pc_stall[0]), 32'd0); advance();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    chk("alu.fwd_a_mem", 32'(fwd_a[0]), 32'd2);
    chk("alu.fwd_b_mem", 32'(fwd_b[0]), 32'd2);
    advance();
    set_id(1, 1, 1, 1, 1, 0, 1, 0, 0); cycle();
    set_id(1, 0, 0, 1, 1, 4, 1, 0, 0); cycle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    chk("x0.fwd_a", 32'(fwd_a[0]), 32'd0);
    chk("x0.fwd_b", 32'(fwd_b[0]), 32'd0);
    advance();
    drain();

    // sw in MEM with mem_ready low three cycles, add x9 behind it.
    set_id(1, 1, 2, 1, 1, 0, 0, 0, 1); cycle();
    set_id(1, 1, 1, 1, 1, 9, 1, 0, 0); cycle();
    set_id(1, 2, 2, 1, 1, 10, 1, 0, 0);
    mem_ready = 1'b0;
    repeat (3) begin
      settle();
      chk("wait.pipe_freeze", 32'(pipe_freeze[0]), 32'd1);
      chk("wait.mem_req", 32'(mem_req[0]), 32'd1);
      chk("wait.wb_valid", 32'(wb_valid[0]), 32'd0);
      chk("wait.ex_valid", 32'(ex_valid[0]), 32'd1);
      advance();
    end
    mem_ready = 1'b1;
    settle(); chk("wait.release", 32'(pipe_freeze[0]), 32'd0); advance();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    settle(); chk("wait.next_retires", 32'(wb_regwrite[0]), 32'd1); advance();
    drain();

    // Redirect during a memory wait, then redirect together with load-use.
    set_id(1, 1, 2, 1, 1, 0, 0, 0, 1); cycle();
    set_id(1, 1, 2, 1, 1, 11, 1, 0, 0); cycle();
    set_id(1, 3, 4, 1, 1, 12, 1, 0, 0);
    mem_ready = 1'b0; ex_redirect = 1'b1;
    repeat (2) begin
      settle();
      chk("rdw.no_flush", 32'(ifid_flush[0]), 32'd0);
      chk("rdw.freeze", 32'(pipe_freeze[0]), 32'd1);
      advance();
    end
    mem_ready = 1'b1;
    settle();
    chk("rdw.flush", 32'(ifid_flush[0]), 32'd1);
    chk("rdw.bubble", 32'(idex_bubble[0]), 32'd1);
    chk("rdw.pc_stall", 32'(pc_stall[0]), 32'd0);
    advance();
    drain();
    set_id(1, 0, 0, 0, 0, 5, 1, 1, 1); cycle();
    set_id(1, 5, 0, 1, 0, 6, 1, 0, 0);
    ex_redirect = 1'b1;
    settle();
    chk("rdlu.flush", 32'(ifid_flush[0]), 32'd1);
    chk("rdlu.pc_stall", 32'(pc_stall[0]), 32'd0);
    chk("rdlu.bubble", 32'(idex_bubble[0]), 32'd1);
    advance();
    drain();

    // No-forwarding instance: x7 writer in WB, then a writer in EX.
    reset = 1'b1; cycle(); reset = 1'b0;
    set_id(1, 1, 1, 1, 0, 7, 1, 0, 0); cycle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0); cycle(); cycle();
    set_id(1, 7, 0, 1, 0, 8, 1, 0, 0);
    settle();
    chk("nf.wb_stall", 32'(pc_stall[1]), 32'd1);
    chk("nf.fwd_a", 32'(fwd_a[1]), 32'd0);
    advance();
    settle(); chk("nf.wb_one_cycle", 32'(pc_stall[1]), 32'd0); advance();
    drain();
    set_id(1, 1, 1, 1, 0, 7, 1, 0, 0); cycle();
    set_id(1, 7, 7, 1, 1, 8, 1, 0, 0);
    c_before = int'(sc1);
    repeat (3) begin
      settle();
      chk("nf.ex_stall", 32'(pc_stall[1]), 32'd1);
      chk("nf.fwd_b", 32'(fwd_b[1]), 32'd0);
      advance();
    end
    settle();
    chk("nf.ex_released", 32'(pc_stall[1]), 32'd0);
    chk("nf.count3", 32'(sc1), 32'(c_before + 3));
    advance();
    drain();

    // Long freeze saturates the 4-bit counter; reset while waiting.
    set_id(1, 1, 2, 1, 1, 0, 0, 0, 1); cycle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0); cycle();
    mem_ready = 1'b0;
    repeat (20) cycle();
    settle();
    chk("sat.count", 32'(sc1), 32'd15);
    chk("sat.freeze", 32'(pipe_freeze[1]), 32'd1);
    chk("sat.fsm_wait", 32'(dbg_state[1]), 32'd1);
    advance();
    reset = 1'b1;
    set_id(1, 5, 5, 1, 1, 5, 1, 1, 1);
    cycle();
    reset = 1'b0;
    settle(); chk_quiet(0); chk_quiet(1); advance();
    drain();

    // Random traffic with occasional waits, redirects and resets.
    for (int i = 0; i < 3000; i++) begin
      int k;
      k = int'($urandom_range(0, 3));
      set_id($urandom_range(0, 4) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
             k == 0 || k == 1, k == 1, k == 1 || k == 2);
      mem_ready   = $urandom_range(0, 3) != 0;
      ex_redirect = $urandom_range(0, 7) == 0;
      reset       = $urandom_range(0, 199) == 0;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
